pe_add_sched: RTL and testbench
===============================

// Module: pe_add_sched
// PURPOSE
//  Round-robin scheduler sharing one adder64 CLA instance among NREQ requesters.
//  Each requester issues a valid/ready operand request. Results return on a single
//  tagged response channel with backpressure.
//  Two-stage buffered pipeline: operand register -> adder64 -> result register.
//  Sits between the PE lanes and the shared 64-bit adder datapath.
// PARAMETERS
//  NREQ   4   number of requesters, 2..8
//  ID_W   2   tag width, = clog2(NREQ); checked at elaboration
// PORTS
//  clk        in   1         single clock; all state updates on posedge
//  rst_n      in   1         asynchronous, active-low reset
//  req_valid  in   NREQ      request valid, one bit per requester
//  req_ready  out  NREQ      one-hot grant; request accepted when valid & ready
//  req_a      in   NREQ*64   operand a, requester i at [64*i+63:64*i]
//  req_b      in   NREQ*64   operand b, same packing
//  req_cin    in   NREQ      carry in
//  req_sub    in   NREQ      subtract select (present only with PE_ADD_SUB_EN)
//  rsp_valid  out  1         result valid
//  rsp_ready  in   1         result accept
//  rsp_id     out  ID_W      index of the requester that owns the result
//  rsp_sum    out  64        sum[63:0]
//  rsp_cout   out  1         carry out
// BEHAVIOUR
//  Reset values: req_ready=0, rsp_valid=0, rsp_id=0, rsp_sum=0, rsp_cout=0, rr_ptr=0.
//  Reset is async and may arrive mid-operation: all in-flight ops are dropped,
//  and nothing is replayed.
//  Occupancy FSM on {s1_v,s2_v}, four states:
//   EMPTY (s1_v=0,s2_v=0), S1ONLY (1,0), S2ONLY (0,1), FULL (1,1).
//  adv2 = ~s2_v | rsp_ready  (result register can load)
//  adv1 = ~s1_v | adv2       (operand register can load)
//  Grant: if adv1 and any req_valid, grant exactly one requester.
//   The granted requester is the first valid one at or after rr_ptr, wrapping NREQ-1 -> 0.
//  req_ready is combinational: it is the one-hot grant, gated by adv1.
//   It depends on req_valid and adv1, never on req_a or req_b.
//  On accept of requester g: s1 <= {a,b,cin,g}; rr_ptr <= (g+1) mod NREQ.
//   With no accept, rr_ptr holds.
//  Stage 1: s1 operands drive adder64 combinationally (cin = s1_cin).
//   If adv2 and s1_v, then s2 <= {sum,cout,id}.
//  Latency: request accepted in cycle N -> rsp_valid=1 in cycle N+2 (no stall).
//  Throughput: 1 op/cycle while rsp_ready=1.
//  Backpressure: while rsp_valid & ~rsp_ready, rsp_* hold stable.
//   s1 may still fill once, so FULL is reachable; in FULL, req_ready=0.
//  Simultaneous rsp handshake + s1 advance + new accept in one cycle: all three
//   complete and the FSM stays FULL. No bubble and no drop.
//  A requester holding req_valid while not granted is starved at most NREQ-1 grants.
//  Widths: sum is 64 bits, and cout is the carry out of bit 63. There is no overflow flag.
// CONFIGURATION
//  PE_ADD_SUB_EN defined: req_sub port present and s1 captures the sub bit.
//   sub=1 drives adder b = ~b and adder cin = 1; req_cin is ignored for that op.
//   rsp_cout=1 means no borrow.
//  PE_ADD_SUB_EN undefined: req_sub port absent, and every op is a + b + cin.
// STRUCTURE
//  pe_add_pkg (shared):
//   - PE_ADD_W = 64
//   - function clog2
//   - s1 record typedef {a,b,cin,sub,id}
//   - s2 record typedef {sum,cout,id}
//  Sub-module pe_rr_arbiter (NREQ): inputs req, ptr, en; outputs one-hot gnt and gnt_idx.
//   Purely combinational; rr_ptr is kept in pe_add_sched.
//  Instantiates adder64 once; no other arithmetic in this block.
// TESTING
//  1. Reset, idle: rst_n=0 -> all outputs 0. Release, then req_valid[2]=1,
//     a=5, b=7, cin=1 -> req_ready[2]=1 same cycle; 2 cycles later rsp_valid=1,
//     rsp_id=2, rsp_sum=13, rsp_cout=0.
//  2. Carry-out: a=64'hFFFF_FFFF_FFFF_FFFF, b=1, cin=0 -> rsp_sum=0, rsp_cout=1.
//  3. Round-robin: req_valid=4'b1111 held, rsp_ready=1 -> grant ids 0,1,2,3,0...
//     and rsp_id follows the same order at one per cycle.
//  4. Backpressure: rsp_ready=0 for 5 cycles with all requesters valid.
//     Exactly 2 ops are accepted, then req_ready=0 and rsp_* are stable.
//     On release, results drain in order with no loss or duplication.
//  5. Reset mid-op: assert rst_n=0 while in FULL state -> rsp_valid=0 immediately.
//     After release the first grant goes to requester 0 (rr_ptr=0).
//  6. PE_ADD_SUB_EN: sub=1, a=10, b=3 -> rsp_sum=7, rsp_cout=1.
//     sub=1, a=3, b=10 -> rsp_sum=64'hFFFF_FFFF_FFFF_FFF9, rsp_cout=0.

Source files
------------

// File: rtl/pe_add_pkg.sv
// pe_add_pkg: types and constants shared by the pe_add_sched slice.
// Holds the datapath width, the tag sizing helper, the occupancy FSM
// encoding and the two pipeline register layouts.
package pe_add_pkg;

    localparam int PE_ADD_W        = 64;
    // Widest tag any legal configuration needs (NREQ up to 8)
    localparam int PE_ADD_ID_MAX_W = 3;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            r = r + 1;
        end
        return r;
    endfunction

    // Occupancy encoding is {s1 valid, s2 valid}
    typedef enum logic [1:0] {
        OCC_EMPTY  = 2'b00,
        OCC_S1ONLY = 2'b10,
        OCC_S2ONLY = 2'b01,
        OCC_FULL   = 2'b11
    } occ_t;

    typedef struct packed {
        logic [PE_ADD_W-1:0]        a;
        logic [PE_ADD_W-1:0]        b;
        logic                       cin;
        logic                       sub;
        logic [PE_ADD_ID_MAX_W-1:0] id;
    } s1_t;

    typedef struct packed {
        logic [PE_ADD_W-1:0]        sum;
        logic                       cout;
        logic [PE_ADD_ID_MAX_W-1:0] id;
    } s2_t;

endpackage

// File: rtl/adder64.sv
// adder64: 64-bit carry-lookahead adder, 4-bit lookahead blocks with a
// block-level carry chain. Purely combinational.
module adder64 (
    input  logic [63:0] a,
    input  logic [63:0] b,
    input  logic        cin,
    output logic [63:0] sum,
    output logic        cout
);

    logic [63:0] g;
    logic [63:0] p;
    logic [16:0] bc;
    logic        gb;
    logic        pb;
    logic        c;

    assign g = a & b;
    assign p = a ^ b;

    // Block generate/propagate and carries into each 4-bit block
    always_comb begin
        bc    = '0;
        gb    = 1'b0;
        pb    = 1'b0;
        bc[0] = cin;
        for (int k = 0; k < 16; k++) begin
            pb = &p[4*k +: 4];
            gb = g[4*k+3]
               | (p[4*k+3] & g[4*k+2])
               | (p[4*k+3] & p[4*k+2] & g[4*k+1])
               | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
            bc[k+1] = gb | (pb & bc[k]);
        end
    end

    // Bit sums inside each block from the block carry-in
    always_comb begin
        sum = '0;
        c   = 1'b0;
        for (int k = 0; k < 16; k++) begin
            c = bc[k];
            for (int j = 0; j < 4; j++) begin
                sum[4*k+j] = p[4*k+j] ^ c;
                c          = g[4*k+j] | (p[4*k+j] & c);
            end
        end
    end

    assign cout = bc[16];

endmodule

// File: rtl/pe_rr_arbiter.sv
// pe_rr_arbiter: combinational round-robin pick. Grants the first
// requester at or after ptr (wrapping), and only when en is high.
// gnt_idx reports the pick even when en is low; the pointer lives
// in the parent.
module pe_rr_arbiter #(
    parameter int NREQ = 4,
    parameter int ID_W = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [ID_W-1:0] ptr,
    input  logic            en,
    output logic [NREQ-1:0] gnt,
    output logic [ID_W-1:0] gnt_idx
);

    int              idx;
    logic            found;
    logic [ID_W-1:0] cand;

    // Scan from ptr upward, wrapping once, and keep the first valid hit
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        idx     = 0;
        found   = 1'b0;
        cand    = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            cand = ID_W'(idx);
            if (!found && req[cand]) begin
                found   = 1'b1;
                gnt_idx = cand;
            end
        end
        if (found && en) begin
            gnt[gnt_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/pe_add_sched.sv
// pe_add_sched: shares one adder64 among NREQ valid/ready requesters.
// Pipeline: operand register (_p1) -> adder64 -> result register (_p2),
// results leave on one tagged channel with backpressure.
// Build option: define PE_ADD_SUB_EN to add the req_sub port; a sub op
// computes a + ~b + 1 and rsp_cout=1 then means "no borrow".
module pe_add_sched
    import pe_add_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int ID_W = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NREQ-1:0]          req_valid,
    output logic [NREQ-1:0]          req_ready,
    input  logic [NREQ*PE_ADD_W-1:0] req_a,
    input  logic [NREQ*PE_ADD_W-1:0] req_b,
    input  logic [NREQ-1:0]          req_cin,
`ifdef PE_ADD_SUB_EN
    input  logic [NREQ-1:0]          req_sub,
`endif
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [ID_W-1:0]          rsp_id,
    output logic [PE_ADD_W-1:0]      rsp_sum,
    output logic                     rsp_cout
);

    if (ID_W != clog2(NREQ) || NREQ < 2 || NREQ > 8) begin : g_bad_param
        $error("pe_add_sched: NREQ must be 2..8 and ID_W must equal clog2(NREQ)");
    end

    logic [PE_ADD_W-1:0] a_lane [NREQ];
    logic [PE_ADD_W-1:0] b_lane [NREQ];

    for (genvar i = 0; i < NREQ; i++) begin : g_lane
        assign a_lane[i] = req_a[PE_ADD_W*i +: PE_ADD_W];
        assign b_lane[i] = req_b[PE_ADD_W*i +: PE_ADD_W];
    end

    occ_t                occ_q;
    occ_t                occ_d;
    logic                vld_p1;
    logic                vld_p2;
    logic                adv1;
    logic                adv2;
    logic                arb_en;
    logic                accept;
    logic [NREQ-1:0]     gnt;
    logic [ID_W-1:0]     gnt_idx;
    logic [ID_W-1:0]     rr_ptr;
    logic                sub_sel;
    s1_t                 s1_p1;
    s2_t                 s2_p2;
    logic [PE_ADD_W-1:0] add_b;
    logic                add_cin;
    logic [PE_ADD_W-1:0] add_sum;
    logic                add_cout;
    logic                id_hi_unused;

    assign vld_p1 = occ_q[1];
    assign vld_p2 = occ_q[0];
    assign adv2   = ~vld_p2 | rsp_ready;
    assign adv1   = ~vld_p1 | adv2;
    // Held in reset, nothing may be granted
    assign arb_en = adv1 & rst_n;

    pe_rr_arbiter #(
        .NREQ (NREQ),
        .ID_W (ID_W)
    ) u_arb (
        .req     (req_valid),
        .ptr     (rr_ptr),
        .en      (arb_en),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    assign req_ready = gnt;
    assign accept    = |gnt;

`ifdef PE_ADD_SUB_EN
    assign sub_sel = req_sub[gnt_idx];
`else
    assign sub_sel = 1'b0;
`endif

    // Occupancy state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ_q <= OCC_EMPTY;
        end else begin
            occ_q <= occ_d;
        end
    end

    // Occupancy next state from accept and result handshake
    always_comb begin
        occ_d = occ_q;
        case (occ_q)
            OCC_EMPTY:  occ_d = accept ? OCC_S1ONLY : OCC_EMPTY;
            OCC_S1ONLY: occ_d = accept ? OCC_FULL : OCC_S2ONLY;
            OCC_S2ONLY: begin
                if (rsp_ready) begin
                    occ_d = accept ? OCC_S1ONLY : OCC_EMPTY;
                end else begin
                    occ_d = accept ? OCC_FULL : OCC_S2ONLY;
                end
            end
            OCC_FULL: begin
                if (rsp_ready) begin
                    occ_d = accept ? OCC_FULL : OCC_S2ONLY;
                end
            end
            default: occ_d = OCC_EMPTY;
        endcase
    end

    // Round-robin pointer moves just past the last accepted requester
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= '0;
        end else if (accept) begin
            rr_ptr <= (gnt_idx == ID_W'(NREQ - 1)) ? '0 : gnt_idx + ID_W'(1);
        end
    end

    // ---- stage 0 -> 1: operand register ----
    // Capture the granted requester's operands and tag
    always_ff @(posedge clk) begin
        if (accept) begin
            s1_p1.a   <= a_lane[gnt_idx];
            s1_p1.b   <= b_lane[gnt_idx];
            s1_p1.cin <= req_cin[gnt_idx];
            s1_p1.sub <= sub_sel;
            s1_p1.id  <= PE_ADD_ID_MAX_W'(gnt_idx);
        end
    end

    // Subtract reuses the adder as a + ~b + 1; the request carry is ignored then
    assign add_b   = s1_p1.sub ? ~s1_p1.b : s1_p1.b;
    assign add_cin = s1_p1.sub | s1_p1.cin;

    adder64 u_add (
        .a    (s1_p1.a),
        .b    (add_b),
        .cin  (add_cin),
        .sum  (add_sum),
        .cout (add_cout)
    );

    // ---- stage 1 -> 2: result register ----
    // Load the adder result whenever the result slot is free or draining
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_p2 <= '0;
        end else if (vld_p1 && adv2) begin
            s2_p2.sum  <= add_sum;
            s2_p2.cout <= add_cout;
            s2_p2.id   <= s1_p1.id;
        end
    end

    assign rsp_valid = vld_p2;
    assign rsp_id    = s2_p2.id[ID_W-1:0];
    assign rsp_sum   = s2_p2.sum;
    assign rsp_cout  = s2_p2.cout;

    // Tag bits above ID_W are always zero and never leave the block
    assign id_hi_unused = ^s2_p2.id;

endmodule

// File: tb/tb_pe_add_sched.sv
// tb_pe_add_sched: randomized bench for pe_add_sched with a queue-based
// reference model of the two-deep pipeline and round-robin grant order.
`timescale 1ns/1ps
module tb_pe_add_sched;

    localparam int NREQ = 4;
    localparam int ID_W = 2;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ*64-1:0]   req_a;
    logic [NREQ*64-1:0]   req_b;
    logic [NREQ-1:0]      req_cin;
`ifdef PE_ADD_SUB_EN
    logic [NREQ-1:0]      req_sub;
`endif
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [ID_W-1:0]      rsp_id;
    logic [63:0]          rsp_sum;
    logic                 rsp_cout;

    always #5 clk = ~clk;

    pe_add_sched #(.NREQ(NREQ), .ID_W(ID_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_cin   (req_cin),
`ifdef PE_ADD_SUB_EN
        .req_sub   (req_sub),
`endif
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_sum   (rsp_sum),
        .rsp_cout  (rsp_cout)
    );

    typedef struct {
        int          id;
        logic [64:0] res;   // {cout, sum}
        int          acc;   // cycle of acceptance
    } item_t;

    item_t           q[$];
    int              ptr;
    int              cyc;
    int              n_cmp = 0;
    int              n_fail = 0;

    logic [NREQ-1:0] obs_ready, exp_ready;
    logic            obs_valid, exp_valid;
    logic [ID_W+64:0] obs_rsp, exp_rsp;   // {id, cout, sum}

    task automatic set_lane(input int i, input logic [63:0] a, input logic [63:0] b, input logic cin);
        req_a[i*64 +: 64] = a;
        req_b[i*64 +: 64] = b;
        req_cin[i]        = cin;
    endtask

    task automatic rand_lanes();
        for (int i = 0; i < NREQ; i++) begin
            if ($urandom_range(0, 7) == 0) req_a[i*64 +: 64] = '1;
            else                           req_a[i*64 +: 64] = {$urandom, $urandom};
            req_b[i*64 +: 64] = {$urandom, $urandom};
            req_cin[i]        = 1'($urandom_range(0, 1));
        end
    endtask

    // Samples the DUT at the falling edge, advances the model one cycle,
    // then moves to just after the next rising edge.
    task automatic step();
        int          g;
        int          idx;
        logic [63:0] a;
        logic [63:0] b;
        logic [64:0] r;
        @(negedge clk);
        obs_ready = req_ready;
        obs_valid = rsp_valid;
        obs_rsp   = {rsp_id, rsp_cout, rsp_sum};
        exp_valid = (q.size() > 0) && (cyc - q[0].acc >= 2);
        exp_rsp   = '0;
        if (q.size() > 0) exp_rsp = {ID_W'(q[0].id), q[0].res};
        exp_ready = '0;
        g = -1;
        if (q.size() < 2 || rsp_ready) begin
            for (int k = 0; k < NREQ; k++) begin
                idx = (ptr + k) % NREQ;
                if (g < 0 && req_valid[idx]) g = idx;
            end
        end
        if (g >= 0) exp_ready[g] = 1'b1;
        if (exp_valid && rsp_ready) void'(q.pop_front());
        if (g >= 0) begin
            a = req_a[g*64 +: 64];
            b = req_b[g*64 +: 64];
            r = {1'b0, a} + {1'b0, b} + {64'd0, req_cin[g]};
`ifdef PE_ADD_SUB_EN
            if (req_sub[g]) r = {1'b0, a} + {1'b0, ~b} + 65'd1;
`endif
            q.push_back('{id: g, res: r, acc: cyc});
            ptr = (g + 1) % NREQ;
        end
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        req_valid = '1;
        rsp_ready = 1'b1;
`ifdef PE_ADD_SUB_EN
        req_sub   = '0;
`endif
        rand_lanes();
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_cmp++; if (req_ready !== '0) begin n_fail++; $display("FAIL reset_req_ready got=%b want=0", req_ready); end
        n_cmp++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid got=%b want=0", rsp_valid); end
        n_cmp++; if (rsp_id !== '0) begin n_fail++; $display("FAIL reset_rsp_id got=%0d want=0", rsp_id); end
        n_cmp++; if (rsp_sum !== '0) begin n_fail++; $display("FAIL reset_rsp_sum got=%h want=0", rsp_sum); end
        n_cmp++; if (rsp_cout !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_cout got=%b want=0", rsp_cout); end
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        req_valid = '0;
        q.delete();
        ptr = 0;
        cyc = 0;
    endtask

    task automatic test_basic();
        req_valid = 4'b0100;
        rsp_ready = 1'b1;
        set_lane(2, 64'd5, 64'd7, 1'b1);
        for (int k = 0; k < 3; k++) begin
            step();
            req_valid = '0;
            n_cmp++;
            if (obs_ready !== exp_ready || obs_valid !== exp_valid || (exp_valid && obs_rsp !== exp_rsp)) begin
                n_fail++;
                $display("FAIL basic cyc=%0d ready=%b want=%b valid=%b want=%b rsp=%h want=%h", cyc, obs_ready, exp_ready, obs_valid, exp_valid, obs_rsp, exp_rsp);
            end
            if (k == 0) begin
                n_cmp++;
                if (obs_ready !== 4'b0100) begin n_fail++; $display("FAIL basic_grant got=%b want=0100", obs_ready); end
            end
        end
        n_cmp++;
        if (obs_valid !== 1'b1 || obs_rsp !== {ID_W'(2), 1'b0, 64'd13}) begin
            n_fail++;
            $display("FAIL basic_result valid=%b rsp=%h want valid=1 rsp=%h", obs_valid, obs_rsp, {ID_W'(2), 1'b0, 64'd13});
        end
    endtask

    task automatic test_carry();
        req_valid = 4'b1000;
        set_lane(3, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0);
        for (int k = 0; k < 3; k++) begin
            step();
            req_valid = '0;
            n_cmp++;
            if (obs_ready !== exp_ready || obs_valid !== exp_valid || (exp_valid && obs_rsp !== exp_rsp)) begin
                n_fail++;
                $display("FAIL carry cyc=%0d ready=%b want=%b valid=%b want=%b rsp=%h want=%h", cyc, obs_ready, exp_ready, obs_valid, exp_valid, obs_rsp, exp_rsp);
            end
        end
        n_cmp++;
        if (obs_valid !== 1'b1 || obs_rsp !== {ID_W'(3), 1'b1, 64'd0}) begin
            n_fail++;
            $display("FAIL carry_result valid=%b rsp=%h want valid=1 rsp=%h", obs_valid, obs_rsp, {ID_W'(3), 1'b1, 64'd0});
        end
    endtask

    task automatic test_round_robin();
        req_valid = 4'b1111;
        rsp_ready = 1'b1;
        for (int k = 0; k < 12; k++) begin
            rand_lanes();
            step();
            n_cmp++;
            if (obs_ready !== exp_ready || obs_valid !== exp_valid || (exp_valid && obs_rsp !== exp_rsp)) begin
                n_fail++;
                $display("FAIL rr cyc=%0d ready=%b want=%b valid=%b want=%b rsp=%h want=%h", cyc, obs_ready, exp_ready, obs_valid, exp_valid, obs_rsp, exp_rsp);
            end
            n_cmp++;
            if (obs_ready !== (4'b0001 << (k % 4))) begin
                n_fail++;
                $display("FAIL rr_order step=%0d got=%b want=%b", k, obs_ready, 4'b0001 << (k % 4));
            end
        end
        req_valid = '0;
        repeat (2) begin
            step();
            n_cmp++;
            if (obs_ready !== exp_ready || obs_valid !== exp_valid || (exp_valid && obs_rsp !== exp_rsp)) begin
                n_fail++;
                $display("FAIL rr_drain cyc=%0d ready=%b want=%b valid=%b want=%b rsp=%h want=%h", cyc, obs_ready, exp_ready, obs_valid, exp_valid, obs_rsp, exp_rsp);
            end
        end
    endtask

    task automatic test_backpressure();
        int n_acc;
        int n_out;
        n_acc = 0;
        n_out = 0;
        req_valid = 4'b1111;
        rsp_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            rand_lanes();
            step();
            n_acc += $countones(obs_ready);
            n_cmp++;
            if (obs_ready !== exp_ready || obs_valid !== exp_valid || (exp_valid && obs_rsp !== exp_rsp)) begin
                n_fail++;
                $display("FAIL bp_stall cyc=%0d ready=%b want=%b valid=%b want=%b rsp=%h want=%h", cyc, obs_ready, exp_ready, obs_valid, exp_valid, obs_rsp, exp_rsp);
            end
        end
        n_cmp++;
        if (n_acc !== 2) begin n_fail++; $display("FAIL bp_accepts got=%0d want=2", n_acc); end
        req_valid = '0;
        rsp_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            if (obs_valid) n_out++;
            n_cmp++;
            if (obs_ready !== exp_ready || obs_valid !== exp_valid || (exp_valid && obs_rsp !== exp_rsp)) begin
                n_fail++;
                $display("FAIL bp_drain cyc=%0d ready=%b want=%b valid=%b want=%b rsp=%h want=%h", cyc, obs_ready, exp_ready, obs_valid, exp_valid, obs_rsp, exp_rsp);
            end
        end
        n_cmp++;
        if (n_out !== 2) begin n_fail++; $display("FAIL bp_drained got=%0d want=2", n_out); end
    endtask

    task automatic test_reset_midop();
        req_valid = 4'b1111;
        rsp_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            rand_lanes();
            step();
            n_cmp++;
            if (obs_ready !== exp_ready || obs_valid !== exp_valid || (exp_valid && obs_rsp !== exp_rsp)) begin
                n_fail++;
                $display("FAIL midop_fill cyc=%0d ready=%b want=%b valid=%b want=%b rsp=%h want=%h", cyc, obs_ready, exp_ready, obs_valid, exp_valid, obs_rsp, exp_rsp);
            end
        end
        rst_n = 1'b0;
        #1;
        n_cmp++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL midop_rsp_valid got=%b want=0", rsp_valid); end
        n_cmp++; if (req_ready !== '0) begin n_fail++; $display("FAIL midop_req_ready got=%b want=0", req_ready); end
        q.delete();
        ptr = 0;
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        rsp_ready = 1'b1;
        step();
        n_cmp++;
        if (obs_ready !== 4'b0001) begin n_fail++; $display("FAIL midop_first_grant got=%b want=0001", obs_ready); end
        req_valid = '0;
        repeat (3) begin
            step();
            n_cmp++;
            if (obs_ready !== exp_ready || obs_valid !== exp_valid || (exp_valid && obs_rsp !== exp_rsp)) begin
                n_fail++;
                $display("FAIL midop_drain cyc=%0d ready=%b want=%b valid=%b want=%b rsp=%h want=%h", cyc, obs_ready, exp_ready, obs_valid, exp_valid, obs_rsp, exp_rsp);
            end
        end
    endtask

`ifdef PE_ADD_SUB_EN
    task automatic test_sub();
        logic [64:0] want [2];
        logic [63:0] av [2];
        logic [63:0] bv [2];
        av[0] = 64'd10; bv[0] = 64'd3;  want[0] = {1'b1, 64'd7};
        av[1] = 64'd3;  bv[1] = 64'd10; want[1] = {1'b0, 64'hFFFF_FFFF_FFFF_FFF9};
        rsp_ready = 1'b1;
        for (int t = 0; t < 2; t++) begin
            req_valid  = 4'b0010;
            req_sub    = 4'b0010;
            set_lane(1, av[t], bv[t], 1'b1);
            for (int k = 0; k < 3; k++) begin
                step();
                req_valid = '0;
                n_cmp++;
                if (obs_ready !== exp_ready || obs_valid !== exp_valid || (exp_valid && obs_rsp !== exp_rsp)) begin
                    n_fail++;
                    $display("FAIL sub cyc=%0d ready=%b want=%b valid=%b want=%b rsp=%h want=%h", cyc, obs_ready, exp_ready, obs_valid, exp_valid, obs_rsp, exp_rsp);
                end
            end
            n_cmp++;
            if (obs_valid !== 1'b1 || obs_rsp !== {ID_W'(1), want[t]}) begin
                n_fail++;
                $display("FAIL sub_result case=%0d valid=%b rsp=%h want=%h", t, obs_valid, obs_rsp, {ID_W'(1), want[t]});
            end
        end
        req_sub = '0;
    endtask
`endif

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            req_valid = NREQ'($urandom_range(0, 15));
            rsp_ready = ($urandom_range(0, 3) != 0);
`ifdef PE_ADD_SUB_EN
            req_sub   = NREQ'($urandom_range(0, 15));
`endif
            rand_lanes();
            step();
            n_cmp++;
            if (obs_ready !== exp_ready || obs_valid !== exp_valid || (exp_valid && obs_rsp !== exp_rsp)) begin
                n_fail++;
                $display("FAIL random cyc=%0d ready=%b want=%b valid=%b want=%b rsp=%h want=%h", cyc, obs_ready, exp_ready, obs_valid, exp_valid, obs_rsp, exp_rsp);
            end
        end
        req_valid = '0;
        rsp_ready = 1'b1;
        repeat (4) begin
            step();
            n_cmp++;
            if (obs_ready !== exp_ready || obs_valid !== exp_valid || (exp_valid && obs_rsp !== exp_rsp)) begin
                n_fail++;
                $display("FAIL random_drain cyc=%0d ready=%b want=%b valid=%b want=%b rsp=%h want=%h", cyc, obs_ready, exp_ready, obs_valid, exp_valid, obs_rsp, exp_rsp);
            end
        end
    endtask

    initial begin
        req_a   = '0;
        req_b   = '0;
        req_cin = '0;
        ptr     = 0;
        cyc     = 0;
        test_reset();
        test_basic();
        test_carry();
        test_round_robin();
        test_backpressure();
        test_reset_midop();
`ifdef PE_ADD_SUB_EN
        test_sub();
`endif
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
